// File: rtl/reg_mem_bank.sv
// rtl/reg_mem_bank.sv - addressable bank of wide matrix registers with masked writes and sequenced clear
module reg_mem_bank #(
  parameter  int WIDTH  = 256,
  parameter  int ELEM_W = 16,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int NE     = WIDTH / ELEM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regEN,
  output logic             regReady,
  input  logic             regRW,
  input  logic             regClr,
  input  logic [AW-1:0]    regAddr,
  input  logic [WIDTH-1:0] regWrite,
  input  logic [NE-1:0]    regMask,
  output logic [WIDTH-1:0] regBus,
  output logic             regValid,
  output logic             regFleg
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wrAcc;

  // A clear request in the same cycle takes priority and swallows the write
  assign wrAcc    = (state == IDLE) && !regClr && regEN && !regRW;
  assign regReady = (state == IDLE);

  // Storage array: no reset, only the clear sequence zeroes entries
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wrAcc) begin
        for (int i = 0; i < NE; i++) begin
          if (regMask[i]) begin
            mem[regAddr][i*ELEM_W +: ELEM_W] <= regWrite[i*ELEM_W +: ELEM_W];
          end
        end
      end
    end
  end

  // Control FSM with registered read data, read strobe and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      regBus   <= '0;
      regValid <= 1'b0;
      regFleg  <= 1'b0;
    end else begin
      regValid <= 1'b0;
      regFleg  <= 1'b0;
      case (state)
        IDLE: begin
          if (regClr) begin
            state <= CLEAR;
            cnt   <= '0;
          end else if (regEN) begin
            regFleg <= 1'b1;
            if (regRW) begin
              regBus   <= mem[regAddr];
              regValid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state   <= IDLE;
            regFleg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mem_bank.sv
// tb/tb_reg_mem_bank.sv - randomized self-checking bench for reg_mem_bank against an array model
module tb_reg_mem_bank;

  localparam int WIDTH  = 256;
  localparam int ELEM_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int NE     = WIDTH / ELEM_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             regEN;
  logic             regReady;
  logic             regRW;
  logic             regClr;
  logic [AW-1:0]    regAddr;
  logic [WIDTH-1:0] regWrite;
  logic [NE-1:0]    regMask;
  logic [WIDTH-1:0] regBus;
  logic             regValid;
  logic             regFleg;

  logic [WIDTH-1:0] model [DEPTH];
  int errCnt = 0;
  int chkCnt = 0;

  reg_mem_bank #(.WIDTH(WIDTH), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .regEN(regEN), .regReady(regReady), .regRW(regRW),
    .regClr(regClr), .regAddr(regAddr), .regWrite(regWrite), .regMask(regMask),
    .regBus(regBus), .regValid(regValid), .regFleg(regFleg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd256();
    logic [WIDTH-1:0] v;
    for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic waitReady(input string tag);
    int g = 0;
    while (!regReady && g < 50) begin
      step();
      g++;
    end
    checkVal(tag, regReady, 1);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [NE-1:0] m);
    waitReady("wr_ready");
    regEN = 1'b1; regRW = 1'b0; regAddr = a; regWrite = d; regMask = m;
    step();
    regEN = 1'b0;
    for (int i = 0; i < NE; i++)
      if (m[i]) model[a][i*ELEM_W +: ELEM_W] = d[i*ELEM_W +: ELEM_W];
    checkVal("wr_fleg", regFleg, 1);
    checkVal("wr_valid", regValid, 0);
  endtask

  task automatic doRead(input logic [AW-1:0] a);
    waitReady("rd_ready");
    regEN = 1'b1; regRW = 1'b1; regAddr = a;
    step();
    regEN = 1'b0;
    checkVal("rd_valid", regValid, 1);
    checkVal("rd_data", regBus, model[a]);
    checkVal("rd_fleg", regFleg, 1);
  endtask

  task automatic doClear(input logic withWrite);
    int low = 0;
    int flegEarly = 0;
    waitReady("clr_ready");
    regClr = 1'b1; regEN = withWrite; regRW = 1'b0; regAddr = 3'd2;
    regWrite = '1; regMask = '1;
    step();
    regClr = 1'b0; regEN = 1'b0;
    while (!regReady && low < 50) begin
      if (regFleg) flegEarly++;
      low++;
      step();
    end
    checkVal("clr_low_cycles", low, DEPTH);
    checkVal("clr_fleg", regFleg, 1);
    checkVal("clr_fleg_early", flegEarly, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step();
    checkVal("clr_fleg_pulse", regFleg, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] a5;
    logic [WIDTH-1:0] ones1;
    logic [WIDTH-1:0] expMasked;
    int g;
    int earlyV;

    rst_n = 1'b0; regEN = 1'b0; regRW = 1'b0; regClr = 1'b0;
    regAddr = '0; regWrite = '0; regMask = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_bus", regBus, 0);
    checkVal("rst_valid", regValid, 0);
    checkVal("rst_fleg", regFleg, 0);
    checkVal("rst_ready", regReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full write then read of entry 3, then a single-element masked overwrite
    a5 = {16{16'hA5A5}};
    ones1 = {16{16'h1111}};
    expMasked = {{15{16'hA5A5}}, 16'h1111};
    doWrite(3'd3, a5, '1);
    doRead(3'd3);
    checkVal("a5_const", regBus, a5);
    doWrite(3'd3, ones1, 16'h0001);
    doRead(3'd3);
    checkVal("masked_const", regBus, expMasked);
    doWrite(3'd3, rnd256(), '0);
    doRead(3'd3);
    checkVal("zero_mask_const", regBus, expMasked);

    // Write immediately followed by read of the same address
    doWrite(3'd5, rnd256(), '1);
    doRead(3'd5);

    // Fill all entries, then back-to-back reads one per cycle
    for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), rnd256(), '1);
    regEN = 1'b1; regRW = 1'b1; regAddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      checkVal("b2b_valid", regValid, 1);
      checkVal("b2b_data", regBus, model[i]);
      if (i < DEPTH - 1) regAddr = AW'(i + 1);
      else regEN = 1'b0;
    end
    step();
    checkVal("b2b_valid_drop", regValid, 0);

    // Clear with a simultaneous write that must be dropped
    doClear(1'b1);
    for (int i = 0; i < DEPTH; i++) doRead(AW'(i));

    // Reset in the middle of a clear after three entries are zeroed
    for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), rnd256() | 256'h1, '1);
    doRead(3'd7);
    regClr = 1'b1;
    step();
    regClr = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    checkVal("midclr_bus", regBus, 0);
    checkVal("midclr_valid", regValid, 0);
    checkVal("midclr_fleg", regFleg, 0);
    checkVal("midclr_ready", regReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) doRead(AW'(i));

    // Read held high while the bank is clearing
    regClr = 1'b1;
    step();
    regClr = 1'b0;
    regEN = 1'b1; regRW = 1'b1; regAddr = 3'd6;
    g = 0; earlyV = 0;
    while (!regReady && g < 50) begin
      if (regValid) earlyV++;
      step();
      g++;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    checkVal("hold_ready", regReady, 1);
    checkVal("hold_wait", g, DEPTH);
    step();
    regEN = 1'b0;
    checkVal("hold_valid", regValid, 1);
    checkVal("hold_data", regBus, model[6]);
    checkVal("hold_early_valid", earlyV, 0);
    step();
    checkVal("hold_single_strobe", regValid, 0);

    // Randomized mix of reads, masked writes and occasional clears
    for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), rnd256(), '1);
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 0) doClear(1'($urandom));
      else if (op < 9) doWrite(AW'($urandom), rnd256(), NE'($urandom));
      else doRead(AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
